// File: rtl/arm_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_fetch_stage_pkg
// Description : Constants and helpers shared by the IF stage and its ROM.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Clears the two byte-offset bits so every fetch address is word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_fetch_stage_inst_rom.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom
// Description : Byte-organised instruction ROM with a combinational,
//               big-endian 32-bit word read. The address is reduced to the
//               ROM width, so larger PCs alias into the array.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom
  import arm_fetch_stage_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       data
);

  // Preloaded from outside through the hierarchy (imem.Mem); never written here
  logic [7:0] Mem [0:MEM_BYTES-1];

  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;

  // Word-aligned byte addresses; alignment means the four bytes never wrap
  always_comb begin
    a0 = {addr[ADDR_W-1:2], 2'b00};
    a1 = {addr[ADDR_W-1:2], 2'b01};
    a2 = {addr[ADDR_W-1:2], 2'b10};
    a3 = {addr[ADDR_W-1:2], 2'b11};
  end

  // Lowest address holds the most significant byte
  assign data = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};

endmodule
`default_nettype wire

// File: rtl/arm_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : arm_fetch_stage
// Description : Instruction fetch stage. Holds the PC, reads the ROM word at
//               PC and registers it with PC+4 and a valid bit into IF/ID.
//               Branch redirect flushes IF/ID; stall freezes all state.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_fetch_stage
  import arm_fetch_stage_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             stall_f,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      PC,
  output logic [31:0]      IF_ID_instruction,
  output logic [31:0]      IF_ID_pc_plus4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_q,        pc_d;
  logic [31:0]      instr_q,     instr_d;
  logic [31:0]      pc_plus4_q,  pc_plus4_d;
  logic             valid_q,     valid_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic [31:0]      rom_word;
  logic [31:0]      pc_next_seq;
  logic             unused_tgt_lsbs;

  // Offset bits of the redirect address are discarded by alignment
  assign unused_tgt_lsbs = ^branch_target[1:0];

  inst_rom #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) imem (
    .addr (pc_q[ADDR_W-1:0]),
    .data (rom_word)
  );

  assign pc_next_seq = pc_q + PC_STEP;

  // Next-state selection: redirect beats stall, stall beats advance
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (branch_taken) begin
      pc_d       = align_word(branch_target);
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'd0;
      valid_d    = 1'b0;
    end else if (!stall_f) begin
      pc_d       = pc_next_seq;
      instr_d    = rom_word;
      pc_plus4_d = pc_next_seq;
      valid_d    = 1'b1;
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // PC, IF/ID register and fetch counter with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign PC                = pc_q;
  assign IF_ID_instruction = instr_q;
  assign IF_ID_pc_plus4    = pc_plus4_q;
  assign IF_ID_valid       = valid_q;
  assign fetch_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_fetch_stage
// Description : Scoreboard bench for arm_fetch_stage. A reference model of
//               the fetch rules produces expected outputs per clock; a
//               monitor compares them against the DUT on the falling edge.
//               A second instance with a 3-bit counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        stall_f = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;

  logic [31:0] pc, instr, pc4;
  logic        valid;
  logic [15:0] cnt;
  logic [31:0] pc_b, instr_b, pc4_b;
  logic        valid_b;
  logic [2:0]  cnt_b;

  arm_fetch_stage #(.MEM_BYTES(256), .ADDR_W(8), .CNT_W(16)) uut (
    .Clk(Clk), .Reset(Reset), .stall_f(stall_f), .branch_taken(branch_taken),
    .branch_target(branch_target), .PC(pc), .IF_ID_instruction(instr),
    .IF_ID_pc_plus4(pc4), .IF_ID_valid(valid), .fetch_count(cnt)
  );

  arm_fetch_stage #(.MEM_BYTES(256), .ADDR_W(8), .CNT_W(3)) uut3 (
    .Clk(Clk), .Reset(Reset), .stall_f(stall_f), .branch_taken(branch_taken),
    .branch_target(branch_target), .PC(pc_b), .IF_ID_instruction(instr_b),
    .IF_ID_pc_plus4(pc4_b), .IF_ID_valid(valid_b), .fetch_count(cnt_b)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    int          cnt;
    int          cnt3;
  } exp_t;

  exp_t sb[$];

  byte unsigned rom [256];
  logic [31:0]  m_pc, m_instr, m_pc4;
  logic         m_valid;
  int           m_cnt, m_cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  // Big-endian word at a byte address, aliased into the 256-byte ROM
  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    b = int'(a % 256);
    b = b - (b % 4);
    return {rom[b], rom[b+1], rom[b+2], rom[b+3]};
  endfunction

  // Apply one cycle of inputs, then advance the model over that edge
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    exp_t e;
    Reset = r; stall_f = s; branch_taken = b; branch_target = t;
    @(posedge Clk);
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_cnt3 = 0;
    end else if (b) begin
      m_pc = t & 32'hFFFF_FFFC; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = word_at(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.cnt = m_cnt; e.cnt3 = m_cnt3;
    sb.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("PC", pc, e.pc);
        check("IF_ID_instruction", instr, e.instr);
        check("IF_ID_pc_plus4", pc4, e.pc4);
        check("IF_ID_valid", {31'd0, valid}, {31'd0, e.valid});
        check("fetch_count", {16'd0, cnt}, e.cnt);
        check("fetch_count_w3", {29'd0, cnt_b}, e.cnt3);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    {rom[0],  rom[1],  rom[2],  rom[3]}  = 32'hE3A00001;
    {rom[4],  rom[5],  rom[6],  rom[7]}  = 32'hE3A01002;
    {rom[8],  rom[9],  rom[10], rom[11]} = 32'hE0802001;
    {rom[12], rom[13], rom[14], rom[15]} = 32'hEAFFFFFE;
    for (int i = 0; i < 256; i++) uut.imem.Mem[i] = rom[i];

    // Reset for 3 cycles, then straight-line fetch
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // Stall two cycles at PC=8, then release
    repeat (2) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // Redirect to 0x22 while stalled
    step(0, 1, 1, 32'h22);
    repeat (3) step(0, 0, 0, 0);
    // Reset asserted during a stall and during a redirect
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 1, 32'h40);
    step(0, 0, 0, 0);
    // Wrap from the top of the address space, aliasing into the ROM
    step(0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h8000_00F7);
    repeat (2) step(0, 0, 0, 0);
    // Counter saturation on the 3-bit instance
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom);
    end
    repeat (2) @(negedge Clk);
    if (sb.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
